parametric_program_counter: RTL

Registered, parametrised program counter for the SuperSpeedCPU fetch path, generalising the combinational 10-bit incrementer into a clocked register. Each cycle it holds, increments by one, loads an absolute address, or applies a signed relative branch offset. It supports wrap-around or saturating arithmetic and reports overflow through a sticky flag and a one-cycle wrap pulse.

---
 rtl/parametric_program_counter_pkg.sv | 30 +++
 rtl/parametric_program_counter_n_bit_incrementer.sv | 16 +
 rtl/parametric_program_counter.sv | 113 +++++++++++
 3 files changed

// File: rtl/parametric_program_counter_pkg.sv
// Shared definitions for the parametric program counter family.
// Provides the arithmetic-mode constants, the per-cycle operation
// encoding and the priority function that picks one operation.
package parametric_program_counter_pkg;

    localparam bit MODE_WRAP     = 1'b0;
    localparam bit MODE_SATURATE = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_INC    = 2'd1,
        OP_BRANCH = 2'd2,
        OP_LOAD   = 2'd3
    } pc_op_e;

    // load > branch > increment > hold
    function automatic pc_op_e select_op(input logic i_load,
                                         input logic i_branch,
                                         input logic i_en);
        if (i_load)
            return OP_LOAD;
        else if (i_branch)
            return OP_BRANCH;
        else if (i_en)
            return OP_INC;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/parametric_program_counter_n_bit_incrementer.sv
// n_bit_incrementer: combinational +1 with carry-out, any WIDTH.
// Ports:
//   i_a     - operand
//   o_sum   - low WIDTH bits of i_a + 1
//   o_carry - carry-out (set only when i_a is all ones)
module n_bit_incrementer #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/parametric_program_counter.sv
// parametric_program_counter: registered fetch-path program counter.
// Each cycle holds, increments, loads an absolute address or adds a
// signed relative offset, with wrap-around or saturating arithmetic.
// Ports:
//   i_clk, i_rst       - clock (rising edge), async active-high reset
//   i_en               - increment request
//   i_load, i_load_value - absolute load request and address
//   i_branch, i_offset - relative branch request and signed offset
//   i_clear_overflow   - clears the sticky overflow flag
//   o_count            - current program counter
//   o_overflow         - sticky out-of-range flag
//   o_wrap             - one-cycle pulse after an out-of-range edge
module parametric_program_counter
    import parametric_program_counter_pkg::*;
#(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SATURATE    = MODE_WRAP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_branch,
    input  logic [WIDTH-1:0] i_offset,
    input  logic             i_clear_overflow,
    output logic [WIDTH-1:0] o_count,
    output logic             o_overflow,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic             r_wrap;

    pc_op_e           w_op;
    logic [WIDTH-1:0] w_inc_sum;
    logic             w_inc_carry;
    logic [WIDTH+1:0] w_br_sum;
    logic             w_br_high;
    logic             w_br_low;
    logic [WIDTH-1:0] w_next_count;
    logic             w_event;

    n_bit_incrementer #(.WIDTH(WIDTH)) u_inc (
        .i_a     (r_count),
        .o_sum   (w_inc_sum),
        .o_carry (w_inc_carry)
    );

    assign w_op = select_op(i_load, i_branch, i_en);

    // Count is zero-extended and offset sign-extended by two bits, so the
    // top bit is the sign of the true result and the next bit flags a
    // result at or above 2^WIDTH.
    assign w_br_sum  = {2'b00, r_count} + {{2{i_offset[WIDTH-1]}}, i_offset};
    assign w_br_low  = w_br_sum[WIDTH+1];
    assign w_br_high = ~w_br_sum[WIDTH+1] & w_br_sum[WIDTH];

    always_comb begin
        w_next_count = r_count;
        w_event      = 1'b0;
        case (w_op)
            OP_LOAD: begin
                w_next_count = i_load_value;
            end
            OP_BRANCH: begin
                w_next_count = w_br_sum[WIDTH-1:0];
                if (w_br_high) begin
                    w_event = 1'b1;
                    if (SATURATE) w_next_count = MAX_COUNT;
                end else if (w_br_low) begin
                    w_event = 1'b1;
                    if (SATURATE) w_next_count = '0;
                end
            end
            OP_INC: begin
                w_next_count = w_inc_sum;
                if (w_inc_carry) begin
                    w_event = 1'b1;
                    if (SATURATE) w_next_count = MAX_COUNT;
                end
            end
            default: begin
                w_next_count = r_count;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= RESET_VALUE;
            r_overflow <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_wrap  <= w_event;
            // A new event beats a simultaneous clear.
            if (w_event)
                r_overflow <= 1'b1;
            else if (i_clear_overflow)
                r_overflow <= 1'b0;
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_wrap     = r_wrap;

endmodule
